// File: rtl/lif_mux_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array: CH channels share one
// two-stage datapath, with per-channel membrane/refractory state held in a RAM.
module lif_mux_array #(
   parameter int CH  = 50,
   parameter int CHW = 6,
   parameter int DW  = 14,
   parameter int KW  = 15,
   parameter int RW  = 4
) (
   input  logic           clk_in,
   input  logic           reset_n,
   input  logic           clear,
   input  logic           in_valid,
   input  logic [CHW-1:0] in_ch,
   input  logic [DW-1:0]  in_data,
   output logic           in_ready,
   input  logic [DW-1:0]  tau,
   input  logic [KW-1:0]  charge_rate,
   input  logic [DW-1:0]  Vrst,
   input  logic [DW-1:0]  Vth,
   input  logic [RW-1:0]  refrac,
   output logic           out_valid,
   output logic [CHW-1:0] out_ch,
   output logic           post_spike,
   output logic [DW-1:0]  vmem_out,
   output logic           frame_done
);

   localparam int             FB      = 14;
   localparam int             MEM_D   = 1 << CHW;
   localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

   // Depth covers the full index range so out-of-range reads stay defined.
   logic [DW-1:0] v_mem [MEM_D];
   logic [RW-1:0] r_mem [MEM_D];

   logic           sweep_active_reg;
   logic [CHW-1:0] sweep_idx_reg;

   logic           s1_valid_reg;
   logic [CHW-1:0] s1_ch_reg;
   logic [DW-1:0]  s1_data_reg;
   logic [DW-1:0]  rd_v_reg;
   logic [RW-1:0]  rd_r_reg;
   logic           byp_reg;
   logic [DW-1:0]  byp_v_reg;
   logic [RW-1:0]  byp_r_reg;

   logic           accept;
   logic           in_range;
   logic [DW-1:0]  v_cur;
   logic [RW-1:0]  r_cur;
   logic [2*DW-1:0]  leak_prod;
   logic [DW+KW-1:0] chg_prod;
   logic [DW+1:0]  leak_sh;
   logic [DW+1:0]  chg_sh;
   logic [DW+1:0]  u_sum;
   logic [DW-1:0]  u_sat;
   logic [DW-1:0]  v_next;
   logic [RW-1:0]  r_next;
   logic           spike_next;

   assign in_ready = ~sweep_active_reg;
   assign accept   = in_valid & in_ready;
   assign in_range = ({1'b0, in_ch} < (CHW + 1)'(CH));

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         sweep_active_reg <= 1'b1;
         sweep_idx_reg    <= '0;
      end else if (clear) begin
         sweep_active_reg <= 1'b1;
         sweep_idx_reg    <= '0;
      end else if (sweep_active_reg) begin
         if (sweep_idx_reg == LAST_CH)
            sweep_active_reg <= 1'b0;
         else
            sweep_idx_reg <= sweep_idx_reg + CHW'(1);
      end
   end

   // Sweep writes take priority over a write-back left in flight by clear.
   always_ff @(posedge clk_in) begin
      if (sweep_active_reg) begin
         v_mem[sweep_idx_reg] <= Vrst;
         r_mem[sweep_idx_reg] <= '0;
      end else if (s1_valid_reg) begin
         v_mem[s1_ch_reg] <= v_next;
         r_mem[s1_ch_reg] <= r_next;
      end
      rd_v_reg <= v_mem[in_ch];
      rd_r_reg <= r_mem[in_ch];
   end

   // The RAM read returns pre-write data, so a same-channel follower takes the
   // write-back value captured alongside it.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_reg <= 1'b0;
         s1_ch_reg    <= '0;
         s1_data_reg  <= '0;
         byp_reg      <= 1'b0;
         byp_v_reg    <= '0;
         byp_r_reg    <= '0;
      end else begin
         s1_valid_reg <= accept & in_range;
         if (accept) begin
            s1_ch_reg   <= in_ch;
            s1_data_reg <= in_data;
            byp_reg     <= s1_valid_reg && (in_ch == s1_ch_reg);
            byp_v_reg   <= v_next;
            byp_r_reg   <= r_next;
         end
      end
   end

   assign v_cur = byp_reg ? byp_v_reg : rd_v_reg;
   assign r_cur = byp_reg ? byp_r_reg : rd_r_reg;

   always_comb begin
      leak_prod  = {{DW{1'b0}}, v_cur} * {{DW{1'b0}}, tau};
      chg_prod   = {{KW{1'b0}}, s1_data_reg} * {{DW{1'b0}}, charge_rate};
      leak_sh    = (DW + 2)'(leak_prod >> FB);
      chg_sh     = (DW + 2)'(chg_prod >> FB);
      // leak never exceeds V since tau < 1.0, so the difference stays non-negative.
      u_sum      = {2'b00, v_cur} - leak_sh + chg_sh;
      u_sat      = (u_sum > {2'b00, {DW{1'b1}}}) ? '1 : u_sum[DW-1:0];
      v_next     = u_sat;
      r_next     = '0;
      spike_next = 1'b0;
      if (r_cur != '0) begin
         v_next = Vrst;
         r_next = r_cur - RW'(1);
      end else if (u_sat >= Vth) begin
         v_next     = Vrst;
         r_next     = refrac;
         spike_next = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_ch     <= '0;
         post_spike <= 1'b0;
         vmem_out   <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= s1_valid_reg;
         frame_done <= s1_valid_reg && (s1_ch_reg == LAST_CH);
         if (s1_valid_reg) begin
            out_ch     <= s1_ch_reg;
            post_spike <= spike_next;
            vmem_out   <= v_next;
         end
      end
   end

endmodule

// File: tb/tb_lif_mux_array.sv
// Directed scoreboard bench for lif_mux_array (CH=4): stimulus pushes expected
// results, a negedge monitor pops and compares every presented result.
module tb_lif_mux_array;

   localparam int CH  = 4;
   localparam int CHW = 3;
   localparam int DW  = 14;
   localparam int KW  = 15;
   localparam int RW  = 4;

   logic           clk_in = 1'b0;
   logic           reset_n = 1'b1;
   logic           clear = 1'b0;
   logic           in_valid = 1'b0;
   logic [CHW-1:0] in_ch = '0;
   logic [DW-1:0]  in_data = '0;
   logic           in_ready;
   logic [DW-1:0]  tau = '0;
   logic [KW-1:0]  charge_rate = KW'(16384);
   logic [DW-1:0]  Vrst = '0;
   logic [DW-1:0]  Vth = DW'(1000);
   logic [RW-1:0]  refrac = '0;
   logic           out_valid;
   logic [CHW-1:0] out_ch;
   logic           post_spike;
   logic [DW-1:0]  vmem_out;
   logic           frame_done;

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic           spike;
      logic [DW-1:0]  vmem;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_assert = 0;
   int   n_fail = 0;

   lif_mux_array #(.CH(CH), .CHW(CHW), .DW(DW), .KW(KW), .RW(RW)) dut (
      .clk_in(clk_in), .reset_n(reset_n), .clear(clear),
      .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data), .in_ready(in_ready),
      .tau(tau), .charge_rate(charge_rate), .Vrst(Vrst), .Vth(Vth), .refrac(refrac),
      .out_valid(out_valid), .out_ch(out_ch), .post_spike(post_spike),
      .vmem_out(vmem_out), .frame_done(frame_done)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk_in) begin
      if (reset_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL unexpected_result: got result on ch %0d vmem %0d, expected none", out_ch, vmem_out);
            end else begin
               mon_e = exp_q.pop_front();
               $display("result ch=%0d spike=%0d vmem=%0d frame_done=%0d", out_ch, post_spike, vmem_out, frame_done);
               check("out_ch", 32'(out_ch), 32'(mon_e.ch));
               check("post_spike", 32'(post_spike), 32'(mon_e.spike));
               check("vmem_out", 32'(vmem_out), 32'(mon_e.vmem));
               check("frame_done", 32'(frame_done), (mon_e.ch == CHW'(CH - 1)) ? 32'd1 : 32'd0);
            end
         end else begin
            check("frame_done_idle", 32'(frame_done), 32'd0);
         end
      end
   end

   task automatic expect_res(input int ch, input int spike, input int vmem);
      exp_t e;
      e.ch    = CHW'(ch);
      e.spike = spike[0];
      e.vmem  = DW'(vmem);
      exp_q.push_back(e);
   endtask

   task automatic drive1(input int ch, input int data);
      @(negedge clk_in);
      check("in_ready_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_ch    = CHW'(ch);
      in_data  = DW'(data);
   endtask

   task automatic drain();
      @(negedge clk_in);
      in_valid = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic send(input int ch, input int data);
      drive1(ch, data);
      drain();
   endtask

   // Counts edges until in_ready rises, bounded so a stuck sweep still fails.
   task automatic wait_ready(input string name, input int req);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk_in);
         #1;
         n++;
      end
      check(name, 32'(n), 32'(req));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_out_valid"}, 32'(out_valid), 32'd0);
      check({name, "_post_spike"}, 32'(post_spike), 32'd0);
      check({name, "_frame_done"}, 32'(frame_done), 32'd0);
      check({name, "_out_ch"}, 32'(out_ch), 32'd0);
      check({name, "_vmem_out"}, 32'(vmem_out), 32'd0);
      check({name, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic do_clear();
      @(negedge clk_in);
      clear = 1'b1;
      @(posedge clk_in);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and sweep timing
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk_in);
      check_reset_outputs("reset");
      #2 reset_n = 1'b1;
      check("in_ready_after_release", 32'(in_ready), 32'd0);
      wait_ready("sweep_len_reset", CH);
      do_clear();
      repeat (2) @(posedge clk_in);
      #1 check("in_ready_mid_sweep", 32'(in_ready), 32'd0);
      do_clear();
      wait_ready("sweep_len_restart", CH);

      // Integrate/fire then refractory on ch 2
      refrac = RW'(2);
      expect_res(2, 0, 400); send(2, 400);
      expect_res(2, 0, 800); send(2, 400);
      expect_res(2, 1, 0);   send(2, 400);
      expect_res(2, 0, 0);   send(2, 400);
      expect_res(2, 0, 0);   send(2, 400);
      expect_res(2, 0, 400); send(2, 400);

      // Leak on ch 0
      refrac = '0;
      tau = DW'(8192);
      Vth = DW'(16383);
      expect_res(0, 0, 1000); send(0, 1000);
      charge_rate = '0;
      expect_res(0, 0, 500); send(0, 0);
      expect_res(0, 0, 250); send(0, 0);
      expect_res(0, 0, 125); send(0, 0);
      charge_rate = KW'(16384);
      expect_res(0, 0, 163); send(0, 100);

      // Saturation and Vth=0
      tau = '0;
      Vrst = DW'(7);
      charge_rate = KW'(32767);
      expect_res(1, 1, 7); send(1, 16383);
      Vth = '0;
      expect_res(1, 1, 7); send(1, 0);
      expect_res(1, 1, 7); send(1, 100);
      expect_res(3, 1, 7); send(3, 0);

      // Clear, then continuous interleaved stream exercising the bypass
      Vrst = '0;
      Vth = DW'(1000);
      charge_rate = KW'(16384);
      do_clear();
      wait_ready("sweep_len_clear", CH);
      expect_res(1, 0, 300); drive1(1, 300);
      expect_res(1, 0, 600); drive1(1, 300);
      expect_res(1, 0, 900); drive1(1, 300);
      expect_res(0, 0, 300); drive1(0, 300);
      expect_res(3, 0, 300); drive1(3, 300);
      drain();
      refrac = RW'(1);
      expect_res(2, 0, 600); drive1(2, 600);
      expect_res(2, 1, 0);   drive1(2, 600);
      expect_res(2, 0, 0);   drive1(2, 600);
      drain();
      send(5, 300);
      expect_res(3, 0, 600); send(3, 300);
      expect_res(2, 0, 600); send(2, 600);

      // Asynchronous reset in the middle of a stream
      refrac = '0;
      expect_res(0, 0, 310); drive1(0, 10);
      expect_res(0, 0, 320); drive1(0, 10);
      expect_res(0, 0, 330); drive1(0, 10);
      expect_res(0, 0, 340); drive1(0, 10);
      @(posedge clk_in);
      #1 check("out_valid_before_reset", 32'(out_valid), 32'd1);
      #1 reset_n = 1'b0;
      in_valid = 1'b0;
      #1 check_reset_outputs("midreset");
      exp_q.delete();
      repeat (2) @(negedge clk_in);
      check_reset_outputs("held_reset");
      reset_n = 1'b1;
      wait_ready("sweep_len_after_reset", CH);
      expect_res(0, 0, 50); send(0, 50);

      repeat (3) @(negedge clk_in);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
